// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operating modes and FSM states.
package shifter_pkg;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shifter_step.sv
// Combinational shift of a word by 0..STEP positions in the selected mode.
// Rotate is built only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise ROL acts as SLL.
module shifter_step
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input  mode_e              i_mode,
  input  logic [WIDTH-1:0]   i_word,
  input  logic [SHAMT_W-1:0] i_n,
  output logic [WIDTH-1:0]   o_word_c,
  output logic               o_carry_c
);

  logic [WIDTH-1:0] w_word;
  logic             w_carry;

  // Unrolled single-bit steps; step i is applied only while i < n.
  always_comb begin
    w_word  = i_word;
    w_carry = 1'b0;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (SHAMT_W'(i) < i_n) begin
        case (i_mode)
          MODE_SRL: begin
            w_carry = w_word[0];
            w_word  = {1'b0, w_word[WIDTH-1:1]};
          end
          MODE_SRA: begin
            w_carry = w_word[0];
            w_word  = {w_word[WIDTH-1], w_word[WIDTH-1:1]};
          end
`ifdef SEQ_SHIFTER_ROTATE_EN
          MODE_ROL: begin
            w_carry = w_word[WIDTH-1];
            w_word  = {w_word[WIDTH-2:0], w_word[WIDTH-1]};
          end
`endif
          default: begin
            w_carry = w_word[WIDTH-1];
            w_word  = {w_word[WIDTH-2:0], 1'b0};
          end
        endcase
      end
    end
  end

  assign o_word_c  = w_word;
  assign o_carry_c = w_carry;

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: Start/Ready handshake, STEP bit positions per clock, one-cycle Done pulse.
// Optional rotate-left mode enabled by defining SEQ_SHIFTER_ROTATE_EN.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [1:0]         i_mode,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_ready,
  output logic               o_done,
  output logic [WIDTH-1:0]   o_result,
  output logic               o_carry
);

  localparam logic [SHAMT_W-1:0] STEP_N = SHAMT_W'(STEP);

  state_e             r_state;
  state_e             w_state_nxt;
  mode_e              r_mode;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic [SHAMT_W-1:0] r_remain;
  logic               r_ready;
  logic               r_done;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_n;
  logic [SHAMT_W-1:0] w_remain_nxt;
  logic [WIDTH-1:0]   w_step_word;
  logic               w_step_carry;

  assign w_accept     = i_start && r_ready;
  assign w_n          = (r_remain > STEP_N) ? STEP_N : r_remain;
  assign w_remain_nxt = r_remain - w_n;

  shifter_step #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W),
    .STEP    (STEP)
  ) u_step (
    .i_mode    (r_mode),
    .i_word    (r_result),
    .i_n       (w_n),
    .o_word_c  (w_step_word),
    .o_carry_c (w_step_carry)
  );

  // State register; Ready/Done are registered decodes of the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt != ST_SHIFT);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  // Next-state logic; DONE accepts a new request with no bubble.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_accept) begin
          w_state_nxt = (i_shamt == '0) ? ST_DONE : ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_remain_nxt == '0) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, otherwise advance one step while shifting.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_remain <= '0;
      r_mode   <= MODE_SLL;
    end else if (w_accept) begin
      r_result <= i_a;
      r_carry  <= 1'b0;
      r_remain <= i_shamt;
      r_mode   <= mode_e'(i_mode);
    end else if (r_state == ST_SHIFT) begin
      r_result <= w_step_word;
      r_carry  <= w_step_carry;
      r_remain <= w_remain_nxt;
    end
  end

  assign o_ready  = r_ready;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_carry  = r_carry;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed self-checking bench for seq_shifter (STEP=1 and STEP=4 instances).
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1;
  logic        start4;
  logic [1:0]  mode;
  logic [15:0] a;
  logic [3:0]  shamt;

  logic        ready1, done1, carry1;
  logic [15:0] res1;
  logic        ready4, done4, carry4;
  logic [15:0] res4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start1),
    .i_mode   (mode),
    .i_a      (a),
    .i_shamt  (shamt),
    .o_ready  (ready1),
    .o_done   (done1),
    .o_result (res1),
    .o_carry  (carry1)
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) dut4 (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_start  (start4),
    .i_mode   (mode),
    .i_a      (a),
    .i_shamt  (shamt),
    .o_ready  (ready4),
    .o_done   (done4),
    .o_result (res4),
    .o_carry  (carry4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample(input bit s4, output logic rdy, output logic dn,
                        output logic [15:0] r, output logic c);
    if (s4) begin
      rdy = ready4; dn = done4; r = res4; c = carry4;
    end else begin
      rdy = ready1; dn = done1; r = res1; c = carry1;
    end
  endtask

  // Issue one request, then poll until Done; returns in the Done cycle.
  task automatic run_op(input string tag, input bit s4, input logic [1:0] m,
                        input logic [15:0] av, input logic [3:0] sh,
                        input logic [15:0] er, input logic ec, input int el);
    int          lat;
    logic        rdy, dn, c;
    logic [15:0] r;
    mode = m; a = av; shamt = sh;
    if (s4) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    mode = ~m; a = ~av; shamt = 4'd0;
    lat = 1;
    sample(s4, rdy, dn, r, c);
    if (sh != 4'd0) check({tag, "_ready_low"}, 32'(rdy), 32'd0);
    while (!dn && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      sample(s4, rdy, dn, r, c);
    end
    check({tag, "_latency"}, 32'(lat), 32'(el));
    check({tag, "_result"}, 32'(r), 32'(er));
    check({tag, "_carry"}, 32'(c), 32'(ec));
    check({tag, "_ready_in_done"}, 32'(rdy), 32'd1);
  endtask

  initial begin
    int          lat;
    bit          seen_done;
    logic [15:0] rol_exp;

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    mode = 2'b00; a = 16'h0; shamt = 4'd0;

    // Reset state, with Start asserted to show it is ignored under reset.
    repeat (2) @(posedge clk);
    #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(ready1), 32'd1);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_result", 32'(res1), 32'd0);
    check("rst_carry", 32'(carry1), 32'd0);
    start1 = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", 32'(ready1), 32'd1);
    check("post_rst_done", 32'(done1), 32'd0);

    run_op("sll", 1'b0, 2'b00, 16'h00F1, 4'd4, 16'h0F10, 1'b0, 5);
    @(posedge clk); #1;
    check("sll_done_pulse", 32'(done1), 32'd0);
    check("sll_hold_result", 32'(res1), 32'h0F10);
    check("sll_hold_carry", 32'(carry1), 32'd0);

    run_op("sra", 1'b0, 2'b10, 16'h8004, 4'd3, 16'hF000, 1'b1, 4);
    @(posedge clk); #1;

    run_op("srl_step4", 1'b1, 2'b01, 16'hFFFF, 4'd15, 16'h0001, 1'b1, 5);
    @(posedge clk); #1;

    run_op("shamt0", 1'b0, 2'b01, 16'h1234, 4'd0, 16'h1234, 1'b0, 1);
    @(posedge clk); #1;

`ifdef SEQ_SHIFTER_ROTATE_EN
    rol_exp = 16'h0003;
`else
    rol_exp = 16'h0002;
`endif
    run_op("mode11", 1'b0, 2'b11, 16'h8001, 4'd1, rol_exp, 1'b1, 2);
    @(posedge clk); #1;

    // Back-to-back: the second request is accepted in the first one's Done cycle.
    run_op("b2b_a", 1'b0, 2'b00, 16'h00F1, 4'd1, 16'h01E2, 1'b0, 2);
    run_op("b2b_b", 1'b0, 2'b00, 16'h0001, 4'd1, 16'h0002, 1'b0, 2);
    @(posedge clk); #1;

    // Start while shifting is ignored and not queued.
    mode = 2'b00; a = 16'h0001; shamt = 4'd3; start1 = 1'b1;
    @(posedge clk); #1;
    mode = 2'b01; a = 16'hFFFF; shamt = 4'd0;
    lat = 1;
    @(posedge clk); #1;
    start1 = 1'b0;
    lat++;
    check("busy_ready_low", 32'(ready1), 32'd0);
    check("busy_no_done", 32'(done1), 32'd0);
    while (!done1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("busy_latency", 32'(lat), 32'd4);
    check("busy_result", 32'(res1), 32'h0008);
    @(posedge clk); #1;
    check("busy_not_queued", 32'(done1), 32'd0);
    check("busy_idle_ready", 32'(ready1), 32'd1);

    // Reset in the middle of a shift.
    mode = 2'b00; a = 16'h00FF; shamt = 4'd8; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_result", 32'(res1), 32'd0);
    check("midrst_carry", 32'(carry1), 32'd0);
    check("midrst_done", 32'(done1), 32'd0);
    check("midrst_ready", 32'(ready1), 32'd1);
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done1) seen_done = 1'b1;
    end
    check("midrst_never_done", 32'(seen_done), 32'd0);
    check("midrst_ready_after", 32'(ready1), 32'd1);
    check("midrst_result_after", 32'(res1), 32'd0);

    run_op("after_rst", 1'b0, 2'b00, 16'h0003, 4'd2, 16'h000C, 1'b0, 3);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
